// File: rtl/universal_shift_pkg.sv
// Shared mode and FSM encodings for the
// universal shift register with sequencer.
package universal_shift_pkg;

    localparam logic [2:0] MODE_LOAD = 3'b000;
    localparam logic [2:0] MODE_SLL  = 3'b001;
    localparam logic [2:0] MODE_SRL  = 3'b010;
    localparam logic [2:0] MODE_SRA  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_HOLD = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/universal_shift_step.sv
// One shift/rotate step; LOAD and HOLD leave q
// alone and report out_valid=0.
module universal_shift_step
    import universal_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] next_q,
    output logic             next_ser_out,
    output logic             out_valid
);

    // Decode the mode into the shifted value and the bit that leaves
    always_comb begin
        next_q       = q;
        next_ser_out = 1'b0;
        out_valid    = 1'b0;
        case (mode)
            MODE_SLL: begin
                next_q       = {q[WIDTH-2:0], ser_in};
                next_ser_out = q[WIDTH-1];
                out_valid    = 1'b1;
            end
            MODE_SRL: begin
                next_q       = {ser_in, q[WIDTH-1:1]};
                next_ser_out = q[0];
                out_valid    = 1'b1;
            end
            MODE_SRA: begin
                next_q       = {q[WIDTH-1], q[WIDTH-1:1]};
                next_ser_out = q[0];
                out_valid    = 1'b1;
            end
            MODE_ROL: begin
                next_q       = {q[WIDTH-2:0], q[WIDTH-1]};
                next_ser_out = q[WIDTH-1];
                out_valid    = 1'b1;
            end
            MODE_ROR: begin
                next_q       = {q[0], q[WIDTH-1:1]};
                next_ser_out = q[0];
                out_valid    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/universal_shift_seq_reg.sv
// Universal shift register: single-step ops in IDLE,
// or a counted run of one op under a small FSM.
module universal_shift_seq_reg
    import universal_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(2*WIDTH)+1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       mode,
    input  logic             step,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [2:0]       op_r, op_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic [WIDTH-1:0] q_n;
    logic             so_n;

    logic [2:0]       sel_mode;
    logic [WIDTH-1:0] sh_q;
    logic             sh_so;
    logic             sh_valid;

    // During a run the latched op drives the shifter, else the live mode
    assign sel_mode = (state == ST_RUN) ? op_r : mode;

    universal_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q           (q),
        .mode        (sel_mode),
        .ser_in      (ser_in),
        .next_q      (sh_q),
        .next_ser_out(sh_so),
        .out_valid   (sh_valid)
    );

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Next-state, sequence counter and datapath selection
    always_comb begin
        state_n = state;
        op_n    = op_r;
        rem_n   = rem;
        q_n     = q;
        so_n    = ser_out;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    op_n  = mode;
                    rem_n = count;
                    if (count == '0) begin
                        state_n = ST_DONE;
                    end else if (mode == MODE_LOAD) begin
                        q_n     = I;
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_RUN;
                    end
                end else if (step) begin
                    if (mode == MODE_LOAD) begin
                        q_n = I;
                    end else if (sh_valid) begin
                        q_n  = sh_q;
                        so_n = sh_so;
                    end
                end
            end
            ST_RUN: begin
                if (sh_valid) begin
                    q_n  = sh_q;
                    so_n = sh_so;
                end
                rem_n = rem - CNT_W'(1);
                if (rem == CNT_W'(1)) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and sequence registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q       <= '0;
            ser_out <= 1'b0;
            op_r    <= MODE_LOAD;
            rem     <= '0;
        end else begin
            q       <= q_n;
            ser_out <= so_n;
            op_r    <= op_n;
            rem     <= rem_n;
        end
    end

endmodule

// File: tb/tb_universal_shift_seq_reg.sv
// Directed bench: driver pushes expected outputs per
// edge, a negedge monitor pops and compares.
module tb_universal_shift_seq_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(2*WIDTH)+1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] I;
    logic [2:0]       mode;
    logic             step;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic       so;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    universal_shift_seq_reg #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .I      (I),
        .mode   (mode),
        .step   (step),
        .start  (start),
        .count  (count),
        .ser_in (ser_in),
        .q      (q),
        .ser_out(ser_out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input string n, input logic [7:0] eq,
                       input logic eso, input logic eb,
                       input logic ed);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = n;
        e.q    = eq;
        e.so   = eso;
        e.busy = eb;
        e.done = ed;
        sb.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (q !== e.q || ser_out !== e.so ||
                busy !== e.busy || done !== e.done) begin
                n_fail++;
                $display("FAIL %s: got q=%h so=%b busy=%b done=%b, want q=%h so=%b busy=%b done=%b",
                         e.name, q, ser_out, busy, done,
                         e.q, e.so, e.busy, e.done);
            end
        end
    end

    logic [7:0] ror_q  [9] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C,
                               8'h06, 8'h03, 8'h81, 8'hC0};
    logic       ror_so [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] sll_q  [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F,
                                8'h3F, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
    logic       sll_so [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        reset_n = 1'b0;
        start   = 1'b1;
        step    = 1'b1;
        mode    = 3'b001;
        count   = 5'd3;
        I       = 8'hFF;
        ser_in  = 1'b1;

        // Reset dominates start and step
        cyc("rst_a", 8'h00, 1'b0, 1'b0, 1'b0);
        cyc("rst_b", 8'h00, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        start   = 1'b0;
        step    = 1'b0;
        cyc("idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // Single steps
        mode = 3'b000; I = 8'hFF; step = 1'b1;
        cyc("step_load_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
        mode = 3'b001; ser_in = 1'b0;
        cyc("step_sll", 8'hFE, 1'b1, 1'b0, 1'b0);

        // SRA run of 3 with a step ignored mid-run
        mode = 3'b000; I = 8'hA8;
        cyc("load_a8", 8'hA8, 1'b1, 1'b0, 1'b0);
        step = 1'b0;
        mode = 3'b011; count = 5'd3; start = 1'b1;
        cyc("sra_start", 8'hA8, 1'b1, 1'b1, 1'b0);
        start = 1'b0; step = 1'b1; mode = 3'b000; I = 8'h00;
        count = 5'd9;
        cyc("sra_1", 8'hD4, 1'b0, 1'b1, 1'b0);
        step = 1'b0;
        cyc("sra_2", 8'hEA, 1'b0, 1'b1, 1'b0);
        cyc("sra_3", 8'hF5, 1'b0, 1'b1, 1'b1);
        cyc("sra_idle", 8'hF5, 1'b0, 1'b0, 1'b0);

        // ROR by 9 wraps modulo width
        mode = 3'b000; I = 8'h81; step = 1'b1;
        cyc("load_81", 8'h81, 1'b0, 1'b0, 1'b0);
        step = 1'b0;
        mode = 3'b101; count = 5'd9; start = 1'b1;
        cyc("ror_start", 8'h81, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 9; i++)
            cyc($sformatf("ror_%0d", i + 1), ror_q[i], ror_so[i],
                1'b1, (i == 8));
        cyc("ror_idle", 8'hC0, 1'b1, 1'b0, 1'b0);

        // SLL by 10 fills fully with ser_in
        mode = 3'b000; I = 8'h00; step = 1'b1;
        cyc("load_00", 8'h00, 1'b1, 1'b0, 1'b0);
        step = 1'b0;
        mode = 3'b001; count = 5'd10; ser_in = 1'b1; start = 1'b1;
        cyc("sll_start", 8'h00, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 10; i++)
            cyc($sformatf("sll_%0d", i + 1), sll_q[i], sll_so[i],
                1'b1, (i == 9));
        cyc("sll_idle", 8'hFF, 1'b1, 1'b0, 1'b0);

        // count==0 goes straight to DONE
        mode = 3'b010; count = 5'd0; start = 1'b1;
        cyc("cnt0_start", 8'hFF, 1'b1, 1'b1, 1'b1);
        start = 1'b0;
        cyc("cnt0_idle", 8'hFF, 1'b1, 1'b0, 1'b0);

        // Reset mid-run aborts with no done
        ser_in = 1'b0; count = 5'd5; start = 1'b1;
        cyc("srl_start", 8'hFF, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        cyc("srl_1", 8'h7F, 1'b1, 1'b1, 1'b0);
        reset_n = 1'b0;
        cyc("srl_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc("post_rst_a", 8'h00, 1'b0, 1'b0, 1'b0);
        cyc("post_rst_b", 8'h00, 1'b0, 1'b0, 1'b0);

        // Start with LOAD ignores count
        mode = 3'b000; I = 8'h3C; count = 5'd7; start = 1'b1;
        cyc("sload_start", 8'h3C, 1'b0, 1'b1, 1'b1);
        start = 1'b0; I = 8'h00;
        cyc("sload_idle", 8'h3C, 1'b0, 1'b0, 1'b0);

        // HOLD and ROL single steps
        mode = 3'b110; step = 1'b1;
        cyc("step_hold", 8'h3C, 1'b0, 1'b0, 1'b0);
        mode = 3'b100;
        cyc("step_rol", 8'h78, 1'b0, 1'b0, 1'b0);
        mode = 3'b111;
        cyc("step_hold7", 8'h78, 1'b0, 1'b0, 1'b0);
        step = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d entries left, want 0",
                     sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
